enigma_keyer: RTL and testbench

// Typist front end for the enigma core: accepts an ASCII character stream
// (valid/ready), turns each letter into a key release/press waveform on the

---
 rtl/enigma_keyer.sv | 138 +++++++++++++
 tb/tb_enigma_keyer.sv | 377 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/enigma_keyer.sv
// Typist front end for the enigma core: ASCII in, key release/press waveform out,
// lamp sampled at the end of the press and returned as an ASCII character.
//
// state   | meaning
// IDLE    | ready for the next character, key released
// RELEASE | key held at IDLE_CODE so the core sees a fresh press
// PRESS   | letter code on key_bits, lamp sampled on the last cycle
// EMIT    | out_char presented until the consumer takes it
module enigma_keyer #(
    parameter int          RELEASE_CYC    = 1,
    parameter int          PRESS_CYC      = 1,
    parameter int          PASS_NONLETTER = 1,
    parameter logic [4:0]  IDLE_CODE      = 5'd31
) (
    input  logic        clk,
    input  logic        restart,
    input  logic [7:0]  in_char,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [4:0]  key_bits,
    input  logic [4:0]  lamp_bits,
    output logic [7:0]  out_char,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        busy,
    output logic        err_lamp,
    output logic [15:0] char_count
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RELEASE,
        S_PRESS,
        S_EMIT
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] timer_q, timer_d;
    logic [4:0]  code_q, code_d;
    logic [4:0]  key_q, key_d;
    logic [7:0]  out_char_q, out_char_d;
    logic        err_q, err_d;
    logic [15:0] count_q, count_d;

    logic is_upper;
    logic is_lower;

    assign is_upper = (in_char >= 8'h41) && (in_char <= 8'h5A);
    assign is_lower = (in_char >= 8'h61) && (in_char <= 8'h7A);

    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        code_d     = code_q;
        key_d      = key_q;
        out_char_d = out_char_q;
        err_d      = err_q;
        count_d    = count_q;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    if (is_upper || is_lower) begin
                        code_d  = is_upper ? 5'(in_char - 8'h41) : 5'(in_char - 8'h61);
                        timer_d = 16'(RELEASE_CYC - 1);
                        state_d = S_RELEASE;
                    end else if (PASS_NONLETTER != 0) begin
                        out_char_d = in_char;
                        state_d    = S_EMIT;
                    end
                end
            end
            S_RELEASE: begin
                if (timer_q == 16'd0) begin
                    key_d   = code_q;
                    timer_d = 16'(PRESS_CYC - 1);
                    state_d = S_PRESS;
                end else begin
                    timer_d = timer_q - 16'd1;
                end
            end
            S_PRESS: begin
                if (timer_q == 16'd0) begin
                    // Out-of-range lamp is reported as '?' and latched as an error.
                    if (lamp_bits <= 5'd25) begin
                        out_char_d = 8'h41 + {3'b000, lamp_bits};
                    end else begin
                        out_char_d = 8'h3F;
                        err_d      = 1'b1;
                    end
                    count_d = count_q + 16'd1;
                    key_d   = IDLE_CODE;
                    state_d = S_EMIT;
                end else begin
                    timer_d = timer_q - 16'd1;
                end
            end
            S_EMIT: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                key_d   = IDLE_CODE;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (restart) begin
            state_q    <= S_IDLE;
            timer_q    <= 16'd0;
            code_q     <= 5'd0;
            key_q      <= IDLE_CODE;
            out_char_q <= 8'd0;
            err_q      <= 1'b0;
            count_q    <= 16'd0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            code_q     <= code_d;
            key_q      <= key_d;
            out_char_q <= out_char_d;
            err_q      <= err_d;
            count_q    <= count_d;
        end
    end

    assign in_ready   = (state_q == S_IDLE) && !restart;
    assign busy       = (state_q != S_IDLE);
    assign out_valid  = (state_q == S_EMIT);
    assign key_bits   = key_q;
    assign out_char   = out_char_q;
    assign err_lamp   = err_q;
    assign char_count = count_q;

endmodule

// File: tb/tb_enigma_keyer.sv
// Bench for enigma_keyer: Caesar-shift lamp model, directed scenarios and a
// randomized stream compared against a character-level reference model.
module tb_enigma_keyer;

    typedef logic [7:0] bq_t[$];

    logic        clk = 1'b0;
    logic        restart = 1'b1;
    logic [7:0]  in_char = 8'h00;
    logic        in_valid = 1'b0;
    logic        in_valid_np = 1'b0;
    logic        out_ready = 1'b1;
    logic        bad_lamp = 1'b0;

    logic        in_ready, out_valid, busy, err_lamp;
    logic [4:0]  key_bits, lamp_bits;
    logic [7:0]  out_char;
    logic [15:0] char_count;

    logic        in_ready_np, out_valid_np, busy_np, err_lamp_np;
    logic [4:0]  key_np, lamp_np;
    logic [7:0]  out_char_np;
    logic [15:0] char_count_np;

    int errors = 0;
    int checks = 0;
    int model_count = 0;

    logic [4:0] press_q[$];
    int         gap_q[$];
    int         plen_q[$];
    int         idle_run = 0;
    int         plen = 0;
    logic [4:0] prev_key = 5'd31;

    always #5 clk = ~clk;

    assign lamp_bits = bad_lamp ? 5'd27 :
                       (key_bits < 5'd26) ? 5'((32'(key_bits) + 3) % 26) : 5'd0;
    assign lamp_np   = (key_np < 5'd26) ? 5'((32'(key_np) + 3) % 26) : 5'd0;

    enigma_keyer #(.RELEASE_CYC(1), .PRESS_CYC(1), .PASS_NONLETTER(1), .IDLE_CODE(5'd31)) dut (
        .clk(clk), .restart(restart), .in_char(in_char), .in_valid(in_valid),
        .in_ready(in_ready), .key_bits(key_bits), .lamp_bits(lamp_bits),
        .out_char(out_char), .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy), .err_lamp(err_lamp), .char_count(char_count)
    );

    enigma_keyer #(.RELEASE_CYC(1), .PRESS_CYC(1), .PASS_NONLETTER(0), .IDLE_CODE(5'd31)) dut_np (
        .clk(clk), .restart(restart), .in_char(in_char), .in_valid(in_valid_np),
        .in_ready(in_ready_np), .key_bits(key_np), .lamp_bits(lamp_np),
        .out_char(out_char_np), .out_valid(out_valid_np), .out_ready(1'b1),
        .busy(busy_np), .err_lamp(err_lamp_np), .char_count(char_count_np)
    );

    // Records every press on key_bits: code, idle cycles before it, press length.
    always @(negedge clk) begin
        if (key_bits != 5'd31) begin
            if (prev_key == 5'd31) begin
                press_q.push_back(key_bits);
                gap_q.push_back(idle_run);
                plen = 1;
            end else if (key_bits == prev_key) begin
                plen++;
            end else begin
                plen_q.push_back(plen);
                press_q.push_back(key_bits);
                gap_q.push_back(0);
                plen = 1;
            end
            idle_run = 0;
        end else begin
            if (prev_key != 5'd31) plen_q.push_back(plen);
            idle_run++;
        end
        prev_key = key_bits;
    end

    function automatic int letter_code(input logic [7:0] ch);
        if (ch >= 8'h41 && ch <= 8'h5A) return int'(ch) - 65;
        if (ch >= 8'h61 && ch <= 8'h7A) return int'(ch) - 97;
        return -1;
    endfunction

    function automatic logic [7:0] model_out(input logic [7:0] ch, input bit bad);
        int c;
        c = letter_code(ch);
        if (c < 0) return ch;
        if (bad) return 8'h3F;
        return 8'(65 + (c + 3) % 26);
    endfunction

    function automatic bq_t str2q(input string s);
        bq_t q;
        for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
        return q;
    endfunction

    task automatic accept_char(input logic [7:0] ch);
        @(negedge clk);
        in_char  = ch;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic run_stream(input bq_t chars, input int stall_pct, input bit bad, input string name);
        logic [7:0] exp_q[$];
        logic [4:0] exp_keys[$];
        int idx = 0, got = 0, cyc = 0, viol = 0, c;
        press_q.delete(); gap_q.delete(); plen_q.delete();
        foreach (chars[i]) begin
            c = letter_code(chars[i]);
            exp_q.push_back(model_out(chars[i], bad));
            if (c >= 0) begin
                exp_keys.push_back(5'(c));
                model_count++;
            end
        end
        while ((idx < chars.size() || got < exp_q.size()) && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            if (busy && in_ready) viol++;
            out_ready = ($urandom_range(99) >= stall_pct);
            if (out_valid && out_ready) begin
                checks++;
                if (got >= exp_q.size()) begin
                    errors++;
                    $display("FAIL %s extra_output got=%h", name, out_char);
                end else if (out_char !== exp_q[got]) begin
                    errors++;
                    $display("FAIL %s out_char[%0d] got=%h exp=%h", name, got, out_char, exp_q[got]);
                end
                got++;
            end
            in_valid = (idx < chars.size()) && ($urandom_range(3) != 0);
            if (in_valid) in_char = chars[idx];
            if (in_valid && in_ready) idx++;
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        checks++;
        if (cyc >= 3000) begin
            errors++;
            $display("FAIL %s timeout got=%0d exp=%0d outputs", name, got, exp_q.size());
        end
        checks++;
        if (viol != 0) begin
            errors++;
            $display("FAIL %s in_ready_while_busy got=%0d exp=0", name, viol);
        end
        checks++;
        if (char_count !== 16'(model_count)) begin
            errors++;
            $display("FAIL %s char_count got=%0d exp=%0d", name, char_count, model_count);
        end
        checks++;
        if (press_q.size() != exp_keys.size() || plen_q.size() != exp_keys.size()) begin
            errors++;
            $display("FAIL %s press_count got=%0d exp=%0d", name, press_q.size(), exp_keys.size());
        end else begin
            foreach (exp_keys[i]) begin
                checks++;
                if (press_q[i] !== exp_keys[i] || gap_q[i] < 1 || plen_q[i] != 1) begin
                    errors++;
                    $display("FAIL %s press[%0d] got=%0d gap=%0d len=%0d exp=%0d gap>=1 len=1",
                             name, i, press_q[i], gap_q[i], plen_q[i], exp_keys[i]);
                end
            end
        end
    endtask

    task automatic test_reset;
        restart = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset in_ready got=%b exp=0", in_ready);
        end
        @(negedge clk);
        checks++;
        if (key_bits !== 5'd31 || out_valid !== 1'b0 || out_char !== 8'h00 ||
            err_lamp !== 1'b0 || char_count !== 16'd0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset state got key=%0d ov=%b oc=%h err=%b cnt=%0d busy=%b exp 31/0/00/0/0/0",
                     key_bits, out_valid, out_char, err_lamp, char_count, busy);
        end
        restart = 1'b0;
        model_count = 0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release in_ready got=%b exp=1", in_ready);
        end
    endtask

    task automatic test_single;
        out_ready = 1'b1;
        accept_char(8'h48);
        checks++;
        if (key_bits !== 5'd31 || busy !== 1'b1 || in_ready !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_release got key=%0d busy=%b rdy=%b ov=%b exp 31/1/0/0",
                     key_bits, busy, in_ready, out_valid);
        end
        @(negedge clk);
        checks++;
        if (key_bits !== 5'(letter_code(8'h48)) || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_press got key=%0d ov=%b exp key=7 ov=0", key_bits, out_valid);
        end
        model_count++;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_char !== model_out(8'h48, 1'b0) ||
            key_bits !== 5'd31 || char_count !== 16'(model_count)) begin
            errors++;
            $display("FAIL single_emit got ov=%b oc=%h key=%0d cnt=%0d exp 1/%h/31/%0d",
                     out_valid, out_char, key_bits, char_count, model_out(8'h48, 1'b0), model_count);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL single_done got ov=%b rdy=%b exp 0/1", out_valid, in_ready);
        end
    endtask

    task automatic test_hello;
        run_stream(str2q("HELLO"), 0, 1'b0, "hello");
    endtask

    task automatic test_stall;
        out_ready = 1'b0;
        accept_char(8'h65);
        @(negedge clk);
        checks++;
        if (key_bits !== 5'd4) begin
            errors++;
            $display("FAIL stall_press got key=%0d exp=4", key_bits);
        end
        model_count++;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || out_char !== model_out(8'h65, 1'b0) ||
                in_ready !== 1'b0 || key_bits !== 5'd31) begin
                errors++;
                $display("FAIL stall_hold[%0d] got ov=%b oc=%h rdy=%b key=%0d exp 1/%h/0/31",
                         i, out_valid, out_char, in_ready, key_bits, model_out(8'h65, 1'b0));
            end
        end
        out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || char_count !== 16'(model_count)) begin
            errors++;
            $display("FAIL stall_release got ov=%b rdy=%b cnt=%0d exp 0/1/%0d",
                     out_valid, in_ready, char_count, model_count);
        end
    endtask

    task automatic test_nonletter;
        out_ready = 1'b1;
        accept_char(8'h20);
        checks++;
        if (out_valid !== 1'b1 || out_char !== 8'h20 || key_bits !== 5'd31 ||
            char_count !== 16'(model_count)) begin
            errors++;
            $display("FAIL pass_space got ov=%b oc=%h key=%0d cnt=%0d exp 1/20/31/%0d",
                     out_valid, out_char, key_bits, char_count, model_count);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL pass_done got ov=%b rdy=%b exp 0/1", out_valid, in_ready);
        end
        in_char     = 8'h20;
        in_valid_np = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (out_valid_np !== 1'b0 || in_ready_np !== 1'b1 || busy_np !== 1'b0 || key_np !== 5'd31) begin
                errors++;
                $display("FAIL drop_space[%0d] got ov=%b rdy=%b busy=%b key=%0d exp 0/1/0/31",
                         i, out_valid_np, in_ready_np, busy_np, key_np);
            end
        end
        in_valid_np = 1'b0;
    endtask

    task automatic test_bad_lamp;
        bad_lamp = 1'b1;
        run_stream(str2q("A"), 0, 1'b1, "bad_lamp");
        bad_lamp = 1'b0;
        checks++;
        if (err_lamp !== 1'b1) begin
            errors++;
            $display("FAIL err_set got=%b exp=1", err_lamp);
        end
        run_stream(str2q("B"), 0, 1'b0, "after_bad");
        checks++;
        if (err_lamp !== 1'b1) begin
            errors++;
            $display("FAIL err_sticky got=%b exp=1", err_lamp);
        end
    endtask

    task automatic test_restart_abort;
        out_ready = 1'b1;
        accept_char(8'h5A);
        @(negedge clk);
        checks++;
        if (key_bits !== 5'd25) begin
            errors++;
            $display("FAIL abort_press got key=%0d exp=25", key_bits);
        end
        restart = 1'b1;
        @(negedge clk);
        checks++;
        if (key_bits !== 5'd31 || out_valid !== 1'b0 || in_ready !== 1'b0 ||
            char_count !== 16'd0 || err_lamp !== 1'b0) begin
            errors++;
            $display("FAIL abort_state got key=%0d ov=%b rdy=%b cnt=%0d err=%b exp 31/0/0/0/0",
                     key_bits, out_valid, in_ready, char_count, err_lamp);
        end
        restart = 1'b0;
        model_count = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
                errors++;
                $display("FAIL abort_after[%0d] got rdy=%b ov=%b exp 1/0", i, in_ready, out_valid);
            end
        end
    endtask

    task automatic test_random;
        bq_t chars;
        logic [7:0] punct[4];
        punct[0] = 8'h20; punct[1] = 8'h2E; punct[2] = 8'h31; punct[3] = 8'h7B;
        for (int i = 0; i < 60; i++) begin
            case ($urandom_range(3))
                0: chars.push_back(8'(8'h41 + $urandom_range(25)));
                1: chars.push_back(8'(8'h61 + $urandom_range(25)));
                2: chars.push_back(punct[$urandom_range(3)]);
                default: chars.push_back(8'($urandom_range(255)));
            endcase
        end
        run_stream(chars, 30, 1'b0, "random");
    endtask

    initial begin
        test_reset();
        test_single();
        test_hello();
        test_stall();
        test_nonletter();
        test_bad_lamp();
        test_restart_abort();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1);
    end

endmodule
